// File: rtl/dec_stream_loader.sv
// rtl/dec_stream_loader.sv - byte-serial loader/unloader around the combinational decryption core
//
// Collects a 16-byte ciphertext block, presents it with the select word to the
// core, holds it for SETTLE_CYCLES, captures the plaintext and streams it out.
//
// Parameters:
//    SETTLE_CYCLES  cycles core inputs are held before plaintext capture (1..15)
// Ports:
//    clk, rst_n          clock, asynchronous active-low reset
//    flush               synchronous abort back to FILL
//    key_data, key_we    select word and its write strobe
//    in_data/valid/ready ciphertext byte stream
//    core_ct, core_sel   assembled state and select word to the core
//    core_pt             plaintext from the core
//    out_data/valid/ready/last  plaintext byte stream, last on byte 15
//    blk_cnt             completed-block counter (only with DEC_LOADER_BLKCNT_EN)
//
// Optional feature macro: DEC_LOADER_BLKCNT_EN

module dec_stream_loader #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic [7:0]    key_data,
   input  logic          key_we,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [127:0]  core_ct,
   output logic [7:0]    core_sel,
   input  logic [127:0]  core_pt,
   output logic [7:0]    out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_last
`ifdef DEC_LOADER_BLKCNT_EN
   ,
   output logic [15:0]   blk_cnt
`endif
);

   localparam logic [1:0] FILL   = 2'd0;
   localparam logic [1:0] SETTLE = 2'd1;
   localparam logic [1:0] DRAIN  = 2'd2;

   localparam logic [3:0] SCNT_LAST = 4'(SETTLE_CYCLES - 1);

   logic [1:0]   state;
   logic [3:0]   icnt;
   logic [3:0]   scnt;
   logic [3:0]   ocnt;
   logic [3:0]   ocnt_nxt;
   logic [127:0] pt_buf;

   assign ocnt_nxt = ocnt + 4'd1;

   // Refusing input during flush keeps a byte offered in that cycle from
   // landing in the freshly restarted block.
   assign in_ready = (state == FILL) && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= FILL;
         icnt      <= 4'd0;
         scnt      <= 4'd0;
         ocnt      <= 4'd0;
         core_ct   <= '0;
         core_sel  <= 8'h00;
         pt_buf    <= '0;
         out_data  <= 8'h00;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
`ifdef DEC_LOADER_BLKCNT_EN
         blk_cnt   <= 16'h0000;
`endif
      end else if (flush) begin
         // Key and data buffers are kept; counters restart so stale buffer
         // contents are overwritten before they can be emitted again.
         state     <= FILL;
         icnt      <= 4'd0;
         scnt      <= 4'd0;
         ocnt      <= 4'd0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               // Key only writable before the first byte so a block never
               // sees a key change part-way through.
               if (key_we && (icnt == 4'd0)) begin
                  core_sel <= key_data;
               end
               if (in_valid) begin
                  core_ct[{icnt, 3'b000} +: 8] <= in_data;
                  icnt <= icnt + 4'd1;
                  if (icnt == 4'd15) begin
                     state <= SETTLE;
                  end
               end
            end
            SETTLE: begin
               if (scnt == SCNT_LAST) begin
                  pt_buf <= core_pt;
                  scnt   <= 4'd0;
                  state  <= DRAIN;
               end else begin
                  scnt <= scnt + 4'd1;
               end
            end
            DRAIN: begin
               // First DRAIN cycle loads the output register from the buffer;
               // afterwards each handshake advances to the next byte.
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  out_data  <= pt_buf[7:0];
                  out_last  <= 1'b0;
               end else if (out_ready) begin
                  if (ocnt == 4'd15) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     ocnt      <= 4'd0;
                     state     <= FILL;
`ifdef DEC_LOADER_BLKCNT_EN
                     blk_cnt   <= blk_cnt + 16'd1;
`endif
                  end else begin
                     ocnt     <= ocnt_nxt;
                     out_data <= pt_buf[{ocnt_nxt, 3'b000} +: 8];
                     out_last <= (ocnt_nxt == 4'd15);
                  end
               end
            end
            default: begin
               state <= FILL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dec_stream_loader.sv
// tb/tb_dec_stream_loader.sv - directed self-checking bench for dec_stream_loader

module tb_dec_stream_loader;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;

   logic          flush = 1'b0;
   logic [7:0]    key_data = 8'h00;
   logic          key_we = 1'b0;
   logic [7:0]    in_data = 8'h00;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [127:0]  core_ct;
   logic [7:0]    core_sel;
   logic [127:0]  core_pt;
   logic [7:0]    out_data;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          out_last;

   logic          b_flush = 1'b0;
   logic [7:0]    b_key_data = 8'h00;
   logic          b_key_we = 1'b0;
   logic [7:0]    b_in_data = 8'h00;
   logic          b_in_valid = 1'b0;
   logic          b_in_ready;
   logic [127:0]  b_core_ct;
   logic [7:0]    b_core_sel;
   logic [127:0]  b_core_pt;
   logic [7:0]    b_out_data;
   logic          b_out_valid;
   logic          b_out_ready = 1'b1;
   logic          b_out_last;
   logic          b_good = 1'b0;

`ifdef DEC_LOADER_BLKCNT_EN
   logic [15:0]   blk_cnt;
   logic [15:0]   b_blk_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   assign core_pt   = core_ct ^ {16{8'hA5}};
   // Late-settling core model: wrong (zero) until 3 cycles into SETTLE.
   assign b_core_pt = b_good ? (b_core_ct ^ {16{8'hA5}}) : '0;

   dec_stream_loader #(.SETTLE_CYCLES(1)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .key_data(key_data), .key_we(key_we),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .core_ct(core_ct), .core_sel(core_sel), .core_pt(core_pt),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last)
`ifdef DEC_LOADER_BLKCNT_EN
      , .blk_cnt(blk_cnt)
`endif
   );

   dec_stream_loader #(.SETTLE_CYCLES(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .flush(b_flush),
      .key_data(b_key_data), .key_we(b_key_we),
      .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .core_ct(b_core_ct), .core_sel(b_core_sel), .core_pt(b_core_pt),
      .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_last(b_out_last)
`ifdef DEC_LOADER_BLKCNT_EN
      , .blk_cnt(b_blk_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input logic [7:0] base, input int n, input int ka, input logic [7:0] kva,
                       input int kb, input logic [7:0] kvb);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = base + 8'(i);
         key_we   = (i == ka) || (i == kb);
         key_data = (i == kb) ? kvb : kva;
         tick;
      end
      in_valid = 1'b0;
      key_we   = 1'b0;
   endtask

   // Collects nb bytes; bp selects the 1,0,0,1,0,0 out_ready pattern.
   task automatic drain(input logic [7:0] base, input bit bp, input int nb);
      int j;
      int k;
      logic [7:0] e;
      j = 0;
      k = 0;
      while (j < nb && k < 300) begin
         out_ready = bp ? (k % 3 == 0) : 1'b1;
         if (out_valid) begin
            e = (base + 8'(j)) ^ 8'hA5;
            chk("out_data", out_data, e);
            chk("out_last", out_last, j == 15);
            chk("in_ready_stalled", in_ready, 1'b0);
            if (out_ready) j++;
         end
         k++;
         tick;
      end
      out_ready = 1'b1;
      chk("drain_count", j, nb);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      tick;
      tick;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_core_ct", core_ct, 128'h0);
      chk("rst_core_sel", core_sel, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      tick;

      // basic block with latency check
      fill(8'h00, 16, 0, 8'h00, -1, 8'h00);
      chk("basic_sel", core_sel, 8'h00);
      chk("basic_ct0", core_ct[7:0], 8'h00);
      chk("basic_ct15", core_ct[127:120], 8'h0F);
      chk("lat_t0", out_valid, 1'b0);
      tick;
      chk("lat_t1", out_valid, 1'b0);
      tick;
      chk("lat_t2", out_valid, 1'b1);
      drain(8'h00, 1'b0, 16);
      chk("basic_done_valid", out_valid, 1'b0);
      chk("basic_done_ready", in_ready, 1'b1);

      // key gating: late write ignored, next block takes new key
      fill(8'h20, 16, 0, 8'h3C, 5, 8'hFF);
      chk("keygate_sel", core_sel, 8'h3C);
      drain(8'h20, 1'b0, 16);
      fill(8'h30, 16, 0, 8'hFF, -1, 8'h00);
      chk("keynext_sel", core_sel, 8'hFF);

      // backpressure on the same block
      drain(8'h30, 1'b1, 16);
      chk("bp_done_valid", out_valid, 1'b0);
      chk("bp_done_ready", in_ready, 1'b1);
`ifdef DEC_LOADER_BLKCNT_EN
      chk("blk_cnt_3", blk_cnt, 16'd3);
`endif

      // flush mid-fill, byte offered during flush is refused
      fill(8'h70, 7, -1, 8'h00, -1, 8'h00);
      in_valid = 1'b1;
      in_data  = 8'hEE;
      flush    = 1'b1;
      #1;
      chk("flush_in_ready", in_ready, 1'b0);
      tick;
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_sel_kept", core_sel, 8'hFF);
      fill(8'h10, 16, -1, 8'h00, -1, 8'h00);
      chk("flush_ct0", core_ct[7:0], 8'h10);
      drain(8'h10, 1'b0, 16);

      // asynchronous reset part-way through DRAIN
      fill(8'h50, 16, -1, 8'h00, -1, 8'h00);
      drain(8'h50, 1'b0, 8);
      chk("pre_rst_valid", out_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", out_valid, 1'b0);
      chk("async_rst_ready", in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      tick;
      chk("post_rst_ready", in_ready, 1'b1);
      chk("post_rst_sel", core_sel, 8'h00);
`ifdef DEC_LOADER_BLKCNT_EN
      chk("post_rst_blk_cnt", blk_cnt, 16'd0);
`endif

      // SETTLE_CYCLES=4 instance with a slow core
      for (int i = 0; i < 16; i++) begin
         b_in_valid = 1'b1;
         b_in_data  = 8'h60 + 8'(i);
         tick;
      end
      b_in_valid = 1'b0;
      tick;
      tick;
      tick;
      b_good = 1'b1;
      chk("s4_t3_valid", b_out_valid, 1'b0);
      tick;
      chk("s4_t4_valid", b_out_valid, 1'b0);
      tick;
      chk("s4_t5_valid", b_out_valid, 1'b1);
      for (int j = 0; j < 16; j++) begin
         chk("s4_data", b_out_data, (8'h60 + 8'(j)) ^ 8'hA5);
         chk("s4_last", b_out_last, j == 15);
         tick;
      end
      chk("s4_done_valid", b_out_valid, 1'b0);
      chk("s4_done_ready", b_in_ready, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
